fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter sharing one `sync_fifo` write port among `NUM_CH` requesters in the dsel datapath. Each requester presents data with a valid/ready handshake. The arbiter grants one channel at a time for a burst of up to `MAX_BURST` beats and forwards accepted beats through a registered stage to the FIFO's `wr_en`/`din`. It throttles on the FIFO's `full` flag and `fifo_cnt` so that no beat is ever dropped.

---
 rtl/fifo_wr_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the dsel FIFO write arbiter and its round-robin picker.
package fifo_wr_arb_pkg;

   typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_e;

   localparam int unsigned DEF_MAX_BURST  = 8;
   localparam int unsigned DEF_FIFO_LIMIT = 1022;

   // Channel index width, never below 1 so index ports stay non-empty.
   function automatic int unsigned CH_IDW(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of req searching upward from ptr+1, wrapping.
module rr_pick
   import fifo_wr_arb_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]         req,
   input  logic [CH_IDW(NUM_CH)-1:0] ptr,
   output logic [CH_IDW(NUM_CH)-1:0] idx,
   output logic                      found
);

   localparam int unsigned IDW = CH_IDW(NUM_CH);

   logic [IDW-1:0] cand;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // Walk farthest to nearest so the requester closest after ptr is assigned last and wins.
      for (int unsigned k = NUM_CH; k > 0; k--) begin
         cand = IDW'((32'(ptr) + k) % NUM_CH);
         if (req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo write port among NUM_CH requesters.
// Define FIFO_WR_ARB_STAT_EN to add per-channel accepted-beat counters on stat_beats.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned FIFO_LIMIT = DEF_FIFO_LIMIT,
   parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         ch_valid,
   input  logic [NUM_CH*WIDTH-1:0]   ch_data,
   output logic [NUM_CH-1:0]         ch_ready,
   input  logic                      fifo_full,
   input  logic [ADDR_WIDTH-1:0]     fifo_cnt,
   output logic                      fifo_wr_en,
   output logic [WIDTH-1:0]          fifo_din,
   output logic [CH_IDW(NUM_CH)-1:0] grant_id,
   output logic                      busy
`ifdef FIFO_WR_ARB_STAT_EN
   ,
   output logic [NUM_CH*32-1:0]      stat_beats
`endif
);

   localparam int unsigned          IDW       = CH_IDW(NUM_CH);
   localparam logic [ADDR_WIDTH-1:0] LIMIT    = ADDR_WIDTH'(FIFO_LIMIT);
   localparam logic [7:0]           LAST_BEAT = 8'(MAX_BURST - 1);

   arb_state_e       state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [7:0]       beat_cnt_q, beat_cnt_d;
   logic             wr_en_q;
   logic [WIDTH-1:0] din_q;

   logic [IDW-1:0]   pick_idx;
   logic             pick_found;
   logic             space_ok;
   logic             g_valid;
   logic             xfer;
   logic [WIDTH-1:0] g_data;

   rr_pick #(
      .NUM_CH (NUM_CH)
   ) u_rr_pick (
      .req   (ch_valid),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // FIFO_LIMIT leaves one slot of headroom for the beat already in the write register.
   assign space_ok = !fifo_full && (fifo_cnt < LIMIT);
   assign g_valid  = ch_valid[grant_q];
   assign xfer     = (state_q == ARB_BURST) && g_valid && space_ok;

   always_comb begin
      g_data = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (grant_q == IDW'(i)) begin
            g_data = ch_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      ch_ready   = '0;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               grant_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = ARB_BURST;
            end
         end
         ARB_BURST: begin
            ch_ready[grant_q] = space_ok;
            if (xfer) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
            end
            // A full-FIFO stall alone never ends the burst; only the beat limit or a dropped valid.
            if ((xfer && (beat_cnt_q == LAST_BEAT)) || !g_valid) begin
               state_d  = ARB_IDLE;
               rr_ptr_d = grant_q;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= IDW'(NUM_CH - 1);
         beat_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         wr_en_q    <= xfer;
         if (xfer) begin
            din_q <= g_data;
         end
      end
   end

   assign fifo_wr_en = wr_en_q;
   assign fifo_din   = din_q;
   assign grant_id   = grant_q;
   assign busy       = (state_q == ARB_BURST);

`ifdef FIFO_WR_ARB_STAT_EN
   logic [NUM_CH-1:0][31:0] stat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i] && ch_ready[i]) begin
               stat_q[i] <= stat_q[i] + 32'd1;
            end
         end
      end
   end

   assign stat_beats = stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: per-channel scoreboard plus a cycle-level arbitration model.
module tb_fifo_wr_arbiter;
   import fifo_wr_arb_pkg::*;

   localparam int unsigned NUM_CH     = 4;
   localparam int unsigned WIDTH      = 64;
   localparam int unsigned ADDR_WIDTH = 10;
   localparam int unsigned FIFO_LIMIT = 1022;
   localparam int unsigned MAX_BURST  = 8;
   localparam int unsigned IDW        = CH_IDW(NUM_CH);

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_CH-1:0]       ch_valid;
   logic [NUM_CH*WIDTH-1:0] ch_data;
   logic [NUM_CH-1:0]       ch_ready;
   logic                    fifo_full;
   logic [ADDR_WIDTH-1:0]   fifo_cnt;
   logic                    fifo_wr_en;
   logic [WIDTH-1:0]        fifo_din;
   logic [IDW-1:0]          grant_id;
   logic                    busy;
`ifdef FIFO_WR_ARB_STAT_EN
   logic [NUM_CH*32-1:0]    stat_beats;
`endif

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_CH     (NUM_CH),
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .FIFO_LIMIT (FIFO_LIMIT),
      .MAX_BURST  (MAX_BURST)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ch_valid   (ch_valid),
      .ch_data    (ch_data),
      .ch_ready   (ch_ready),
      .fifo_full  (fifo_full),
      .fifo_cnt   (fifo_cnt),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .grant_id   (grant_id),
      .busy       (busy)
`ifdef FIFO_WR_ARB_STAT_EN
      ,
      .stat_beats (stat_beats)
`endif
   );

   logic [WIDTH-1:0] src_q [NUM_CH][$];
   logic [WIDTH-1:0] exp_q [NUM_CH][$];
   int unsigned      seq_n [NUM_CH];
   int               grant_log [$];
   int               len_log [$];
   int               total = 0;
   int               bad = 0;
   bit               gap_mode = 1'b0;
   bit               rand_fifo = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int log_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NUM_CH; i++) begin
         if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Beat tag: channel in the top byte, per-channel sequence number, random payload.
   task automatic push_beat(input int ch);
      logic [WIDTH-1:0] d;
      d = {8'(ch), 24'(seq_n[ch]), 32'($urandom())};
      seq_n[ch]++;
      src_q[ch].push_back(d);
      exp_q[ch].push_back(d);
   endtask

   task automatic flush();
      for (int i = 0; i < NUM_CH; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      ch_valid = '0;
   endtask

   // One clock: note handshakes just before the edge, then drive the next inputs after it.
   task automatic step();
      logic [NUM_CH-1:0] acc;
      @(negedge clk);
      acc = ch_valid & ch_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (acc[i]) void'(src_q[i].pop_front());
         if (!ch_valid[i] || acc[i]) begin
            if (src_q[i].size() > 0 && (!gap_mode || $urandom_range(3) != 0)) begin
               ch_valid[i] = 1'b1;
               ch_data[i*WIDTH +: WIDTH] = src_q[i][0];
            end else begin
               ch_valid[i] = 1'b0;
            end
         end
      end
      if (rand_fifo) begin
         fifo_full = ($urandom_range(3) == 0);
         fifo_cnt  = ADDR_WIDTH'($urandom_range(1023, 1019));
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (n < budget && !all_empty()) begin
         step();
         n++;
      end
      repeat (3) step();
      total++;
      if (!all_empty()) begin
         bad++;
         $display("FAIL drain: beats still pending after %0d cycles, want none", budget);
      end
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      flush();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   // Reference model: arbitration rules evaluated once per cycle from the sampled inputs.
   task automatic monitor();
      bit m_busy = 1'b0;
      bit m_wr = 1'b0;
      bit prev_busy = 1'b0;
      bit sp, xf, gv, found;
      int m_grant = 0;
      int m_last = NUM_CH - 1;
      int m_beats = 0;
      int burst_xf = 0;
      int c, ch;
      logic [NUM_CH-1:0] er;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_busy = 1'b0;
            m_wr = 1'b0;
            m_last = NUM_CH - 1;
            prev_busy = 1'b0;
            burst_xf = 0;
         end else begin
            sp = !fifo_full && (32'(fifo_cnt) < FIFO_LIMIT);
            er = '0;
            if (m_busy && sp) er[IDW'(m_grant)] = 1'b1;
            chk("busy", 64'(busy), 64'(m_busy));
            if (m_busy) chk("grant_id", 64'(grant_id), 64'(m_grant));
            chk("ch_ready", 64'(ch_ready), 64'(er));
            chk("fifo_wr_en", 64'(fifo_wr_en), 64'(m_wr));
            if (fifo_wr_en) begin
               ch = int'(fifo_din[WIDTH-1 -: 8]);
               if (ch >= NUM_CH || exp_q[ch].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_extra: got %h want no write", fifo_din);
               end else begin
                  chk("sb_data", fifo_din, exp_q[ch].pop_front());
               end
            end
            if (busy) burst_xf += $countones(ch_valid & ch_ready);
            if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
            if (!busy && prev_busy) begin
               len_log.push_back(burst_xf);
               burst_xf = 0;
            end
            prev_busy = busy;

            m_wr = 1'b0;
            if (!m_busy) begin
               found = 1'b0;
               for (int k = 1; k <= NUM_CH; k++) begin
                  c = (m_last + k) % NUM_CH;
                  if (!found && ch_valid[IDW'(c)]) begin
                     found = 1'b1;
                     m_grant = c;
                  end
               end
               if (found) begin
                  m_busy = 1'b1;
                  m_beats = 0;
               end
            end else begin
               gv = ch_valid[IDW'(m_grant)];
               xf = gv && sp;
               if (xf) begin
                  m_wr = 1'b1;
                  m_beats++;
               end
               if ((xf && m_beats == MAX_BURST) || !gv) begin
                  m_busy = 1'b0;
                  m_last = m_grant;
               end
            end
         end
      end
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      ch_valid  = '0;
      ch_data   = '0;
      fifo_full = 1'b0;
      fifo_cnt  = '0;
      for (int i = 0; i < NUM_CH; i++) seq_n[i] = 0;
      fork
         monitor();
      join_none

      #12;
      chk("rst_wr_en", 64'(fifo_wr_en), 64'(0));
      chk("rst_din", fifo_din, 64'(0));
      chk("rst_grant", 64'(grant_id), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_ready", 64'(ch_ready), 64'(0));
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Single channel, three beats.
      grant_log.delete();
      len_log.delete();
      repeat (3) push_beat(1);
      drain(40);
      chk("single_grant", 64'(log_at(grant_log, 0)), 64'(1));
      chk("single_len", 64'(log_at(len_log, 0)), 64'(3));

      // All channels busy: full-length bursts in rotation.
      apply_reset();
      grant_log.delete();
      len_log.delete();
      for (int i = 0; i < NUM_CH; i++) repeat (16) push_beat(i);
      drain(200);
      for (int i = 0; i < 2 * NUM_CH; i++) begin
         chk("rr_order", 64'(log_at(grant_log, i)), 64'(i % NUM_CH));
         chk("rr_len", 64'(log_at(len_log, i)), 64'(MAX_BURST));
      end
`ifdef FIFO_WR_ARB_STAT_EN
      for (int i = 0; i < NUM_CH; i++) begin
         chk("stat_beats", 64'(stat_beats[i*32 +: 32]), 64'(16));
      end
`endif

      // Throttle on fifo_cnt mid-burst.
      grant_log.delete();
      len_log.delete();
      fifo_cnt = ADDR_WIDTH'(1021);
      repeat (MAX_BURST) push_beat(1);
      repeat (3) step();
      fifo_cnt = ADDR_WIDTH'(1022);
      #1;
      chk("thr_ready_low", 64'(ch_ready), 64'(0));
      chk("thr_busy", 64'(busy), 64'(1));
      repeat (3) step();
      fifo_cnt = ADDR_WIDTH'(1021);
      #1;
      chk("thr_ready_back", 64'(ch_ready), 64'(4'b0010));
      drain(60);
      chk("thr_len", 64'(log_at(len_log, 0)), 64'(MAX_BURST));
      fifo_cnt = '0;

      // Early termination: ch2 drops valid after two beats.
      grant_log.delete();
      len_log.delete();
      repeat (2) push_beat(2);
      repeat (2) step();
      repeat (2) push_beat(3);
      repeat (2) push_beat(0);
      drain(60);
      chk("early_g0", 64'(log_at(grant_log, 0)), 64'(2));
      chk("early_g1", 64'(log_at(grant_log, 1)), 64'(3));
      chk("early_g2", 64'(log_at(grant_log, 2)), 64'(0));
      chk("early_len", 64'(log_at(len_log, 0)), 64'(2));

      // Random traffic with valid gaps and FIFO back-pressure.
      gap_mode = 1'b1;
      rand_fifo = 1'b1;
      repeat (400) begin
         if ($urandom_range(3) == 0) push_beat(int'($urandom_range(NUM_CH - 1)));
         step();
      end
      gap_mode = 1'b0;
      rand_fifo = 1'b0;
      fifo_full = 1'b0;
      fifo_cnt = '0;
      drain(800);

      // Reset in the middle of a burst.
      grant_log.delete();
      len_log.delete();
      repeat (12) push_beat(1);
      n = 0;
      while (n < 30 && src_q[1].size() > 8) begin
         step();
         n++;
      end
      chk("rst_mid_beats", 64'(12 - src_q[1].size()), 64'(4));
      chk("rst_mid_wr_pre", 64'(fifo_wr_en), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wr_en", 64'(fifo_wr_en), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_ready", 64'(ch_ready), 64'(0));
      flush();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      grant_log.delete();
      len_log.delete();
      repeat (2) push_beat(1);
      repeat (2) push_beat(2);
      repeat (2) push_beat(0);
      drain(80);
      chk("post_rst_g0", 64'(log_at(grant_log, 0)), 64'(0));
      chk("post_rst_g1", 64'(log_at(grant_log, 1)), 64'(1));
      chk("post_rst_g2", 64'(log_at(grant_log, 2)), 64'(2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
